fp_addsub_seq: RTL

- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor with a valid/ready handshake on both sides.
- Generalises the team's single-precision combinational adder in four ways: configurable exponent and mantissa widths, a subtract mode, round-to-nearest-even with guard/round/sticky bits, and special-value handling.
- Sits between the operand register file and the FP result writeback stage.
- Processes one operation at a time through an FSM with an iterative normaliser.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_align_shift.sv | 23 ++
 rtl/fp_addsub_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FSM type, default-format constants and operand classification
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int EXP_MAX   = (1 << DEF_EXP_W) - 1;
    localparam int FRAC_W    = DEF_MAN_W;
    localparam int SIG_W     = DEF_MAN_W + 4;
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Denormals (exp == 0) classify as zero, which flushes them to signed zero.
    function automatic fp_class_t fp_unpack(input logic [63:0] word, input int exp_w, input int man_w);
        logic [63:0] ones;
        logic [63:0] frac;
        logic [63:0] expf;
        fp_class_t   c;
        ones      = (64'd1 << exp_w) - 64'd1;
        frac      = word & ((64'd1 << man_w) - 64'd1);
        expf      = (word >> man_w) & ones;
        c.sign    = word[exp_w + man_w];
        c.is_zero = (expf == 64'd0);
        c.is_inf  = (expf == ones) && (frac == 64'd0);
        c.is_nan  = (expf == ones) && (frac != 64'd0);
        return c;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// rtl/fp_align_shift.sv - right shifter that folds every shifted-out bit into the sticky LSB
module fp_align_shift #(
    parameter int SIG_W = 27,
    parameter int SH_W  = 10
) (
    input  logic [SIG_W-1:0] sig_in,
    input  logic [SH_W-1:0]  shamt,
    output logic [SIG_W-1:0] sig_out
);
    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] lost_mask;

    assign shifted   = sig_in >> shamt;
    assign lost_mask = ~({SIG_W{1'b1}} << shamt);

    always_comb begin
        if (shamt >= SH_W'(SIG_W)) begin
            sig_out = {{(SIG_W-1){1'b0}}, |sig_in};
        end else begin
            sig_out = shifted | {{(SIG_W-1){1'b0}}, |(sig_in & lost_mask)};
        end
    end
endmodule

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle FP add/subtract with RNE rounding and special-value table
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_ONES = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]             flags_q, flags_d;
    logic                   sign_q, sign_d, eff_sub_q, eff_sub_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [SW-1:0]          xsig_q, xsig_d, ysig_q, ysig_d;
    logic [SW:0]            sum_q, sum_d;

    fp_class_t              ca, cb;
    logic [EXP_W-1:0]       ea, eb, x_exp, y_exp;
    logic [MAN_W-1:0]       fa, fb, x_frac, y_frac;
    logic                   a_ge_b, x_sign, is_special;
    logic [XW-1:0]          diff;
    logic [SW-1:0]          y_shifted;
    logic [W-1:0]           spec_res;
    logic [3:0]             spec_flags;
    logic                   round_up;
    logic [MAN_W+1:0]       mant;
    logic signed [XW-1:0]   exp_r;
    logic [MAN_W-1:0]       frac_r;

    // b_q already carries the effective sign, so the datapath never sees op_sub.
    assign ca = fp_unpack(64'(a_q), EXP_W, MAN_W);
    assign cb = fp_unpack(64'(b_q), EXP_W, MAN_W);
    assign ea = a_q[W-2:MAN_W];
    assign eb = b_q[W-2:MAN_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    assign a_ge_b     = {ea, fa} >= {eb, fb};
    assign x_exp      = a_ge_b ? ea : eb;
    assign y_exp      = a_ge_b ? eb : ea;
    assign x_frac     = a_ge_b ? fa : fb;
    assign y_frac     = a_ge_b ? fb : fa;
    assign x_sign     = a_ge_b ? ca.sign : cb.sign;
    assign diff       = XW'(x_exp) - XW'(y_exp);
    assign is_special = ca.is_zero | ca.is_inf | ca.is_nan | cb.is_zero | cb.is_inf | cb.is_nan;

    fp_align_shift #(.SIG_W(SW), .SH_W(XW)) u_align (
        .sig_in  ({1'b1, y_frac, 3'b000}),
        .shamt   (diff),
        .sig_out (y_shifted)
    );

    always_comb begin
        spec_res   = a_q;
        spec_flags = 4'b0000;
        if (ca.is_nan || cb.is_nan || (ca.is_inf && cb.is_inf && (ca.sign != cb.sign))) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (ca.is_inf) begin
            spec_res = a_q;
        end else if (cb.is_inf) begin
            spec_res = b_q;
        end else if (ca.is_zero && cb.is_zero) begin
            spec_res = {ca.sign & cb.sign, {(W-1){1'b0}}};
        end else if (ca.is_zero) begin
            spec_res = b_q;
        end
    end

    // sum_q bit layout below the carry: {hidden, frac, G, R, S}
    assign round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    assign mant     = {1'b0, sum_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    assign exp_r    = mant[MAN_W+1] ? exp_q + XW'(1) : exp_q;
    assign frac_r   = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        flags_d   = flags_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        xsig_d    = xsig_q;
        ysig_d    = ysig_q;
        sum_d     = sum_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = {b[W-1] ^ op_sub, b[W-2:0]};
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (is_special) begin
                    result_d = spec_res;
                    flags_d  = spec_flags;
                    state_d  = S_DONE;
                end else begin
                    sign_d    = x_sign;
                    eff_sub_d = ca.sign ^ cb.sign;
                    exp_d     = $signed({2'b00, x_exp});
                    xsig_d    = {1'b1, x_frac, 3'b000};
                    ysig_d    = y_shifted;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, xsig_q} - {1'b0, ysig_q})
                                    : ({1'b0, xsig_q} + {1'b0, ysig_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q[SW]) begin
                    sum_d   = {1'b0, sum_q[SW:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + XW'(1);
                    state_d = S_ROUND;
                end else if (sum_q[SW-1]) begin
                    state_d = S_ROUND;
                end else if (sum_q == '0) begin
                    result_d = '0;
                    flags_d  = 4'b0000;
                    state_d  = S_DONE;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - XW'(1);
                    if (exp_q == XW'(1)) begin
                        result_d = {sign_q, {(W-1){1'b0}}};
                        flags_d  = 4'b0011;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ROUND: begin
                if (exp_r >= EXP_ONES) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d  = 4'b0101;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
                    flags_d  = {3'b000, |sum_q[2:0]};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            xsig_q    <= '0;
            ysig_q    <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            xsig_q    <= xsig_d;
            ysig_q    <= ysig_d;
            sum_q     <= sum_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
endmodule
